// File: rtl/uart_tx_scheduler_if.sv
// rtl/uart_tx_scheduler_if.sv - APB bus between the TX scheduler (master) and the UART register slave
interface uart_tx_scheduler_if;
    logic        psel_o;
    logic        penable_o;
    logic        pwrite_o;
    logic [7:0]  paddr_o;
    logic [31:0] pwdata_o;
    logic [31:0] prdata_i;
    logic        pready_i;
    logic        pslverr_i;

    modport master (
        output psel_o, penable_o, pwrite_o, paddr_o, pwdata_o,
        input  prdata_i, pready_i, pslverr_i
    );

    modport slave (
        input  psel_o, penable_o, pwrite_o, paddr_o, pwdata_o,
        output prdata_i, pready_i, pslverr_i
    );
endinterface

// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - round-robin byte scheduler driving the UART TX path over APB (optional init write: UART_TX_SCHED_INIT_EN)
module uart_tx_scheduler #(
    parameter int          N_REQ       = 4,
    parameter logic [7:0]  TXDATA_ADDR = 8'h00,
    parameter logic [7:0]  STATUS_ADDR = 8'h08,
    parameter int          TXFULL_BIT  = 0,
    parameter logic [7:0]  CTRL_ADDR   = 8'h0C,
    parameter logic [31:0] INIT_CTRL   = 32'h0000_0001,
    localparam int         IDW         = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                 pclk_i,
    input  logic                 preset_i,
    input  logic [N_REQ-1:0]     req_valid_i,
    input  logic [8*N_REQ-1:0]   req_data_i,
    output logic [N_REQ-1:0]     req_ready_o,
    uart_tx_scheduler_if.master  apb,
    output logic                 busy_o,
    output logic [IDW-1:0]       grant_id_o,
    output logic                 err_o,
    input  logic                 err_clr_i
);

`ifdef UART_TX_SCHED_INIT_EN
    typedef enum logic [2:0] {IDLE, POLL_S, POLL_A, WR_S, WR_A, INIT_S, INIT_A} state_t;
    localparam state_t RST_STATE = INIT_S;
`else
    typedef enum logic [2:0] {IDLE, POLL_S, POLL_A, WR_S, WR_A} state_t;
    localparam state_t RST_STATE = IDLE;
`endif

    state_t         r_state;
    state_t         w_next;
    logic [IDW-1:0] r_ptr;
    logic [IDW-1:0] r_grant;
    logic [7:0]     r_byte;
    logic           r_err;

    logic           w_found;
    logic [IDW-1:0] w_winner;
    logic [7:0]     w_sel_byte;
    logic           w_accept;
    logic           w_err_set;

    // First valid requester at or after the round-robin pointer, wrapping.
    always_comb begin : p_arb
        int v_idx;
        v_idx      = 0;
        w_found    = 1'b0;
        w_winner   = '0;
        w_sel_byte = '0;
        for (int i = 0; i < N_REQ; i++) begin
            v_idx = int'(r_ptr) + i;
            if (v_idx >= N_REQ) begin
                v_idx = v_idx - N_REQ;
            end
            if (!w_found && req_valid_i[v_idx]) begin
                w_found    = 1'b1;
                w_winner   = v_idx[IDW-1:0];
                w_sel_byte = req_data_i[8*v_idx +: 8];
            end
        end
    end

    always_ff @(posedge pclk_i or posedge preset_i) begin
        if (preset_i) begin
            r_state <= RST_STATE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        w_accept      = 1'b0;
        w_err_set     = 1'b0;
        req_ready_o   = '0;
        busy_o        = (r_state != IDLE);
        apb.psel_o    = 1'b0;
        apb.penable_o = 1'b0;
        apb.pwrite_o  = 1'b0;
        apb.paddr_o   = '0;
        apb.pwdata_o  = '0;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    req_ready_o[w_winner] = 1'b1;
                    w_accept              = 1'b1;
                    w_next                = POLL_S;
                end
            end
            POLL_S: begin
                apb.psel_o  = 1'b1;
                apb.paddr_o = STATUS_ADDR;
                w_next      = POLL_A;
            end
            POLL_A: begin
                apb.psel_o    = 1'b1;
                apb.penable_o = 1'b1;
                apb.paddr_o   = STATUS_ADDR;
                if (apb.pready_i) begin
                    if (apb.pslverr_i) begin
                        w_err_set = 1'b1;
                        w_next    = POLL_S;
                    end else if (apb.prdata_i[TXFULL_BIT]) begin
                        w_next = POLL_S;
                    end else begin
                        w_next = WR_S;
                    end
                end
            end
            WR_S: begin
                apb.psel_o   = 1'b1;
                apb.pwrite_o = 1'b1;
                apb.paddr_o  = TXDATA_ADDR;
                apb.pwdata_o = {24'h0, r_byte};
                w_next       = WR_A;
            end
            WR_A: begin
                apb.psel_o    = 1'b1;
                apb.penable_o = 1'b1;
                apb.pwrite_o  = 1'b1;
                apb.paddr_o   = TXDATA_ADDR;
                apb.pwdata_o  = {24'h0, r_byte};
                // An errored write is not retried: the byte is dropped.
                if (apb.pready_i) begin
                    w_err_set = apb.pslverr_i;
                    w_next    = IDLE;
                end
            end
`ifdef UART_TX_SCHED_INIT_EN
            INIT_S: begin
                apb.psel_o   = 1'b1;
                apb.pwrite_o = 1'b1;
                apb.paddr_o  = CTRL_ADDR;
                apb.pwdata_o = INIT_CTRL;
                w_next       = INIT_A;
            end
            INIT_A: begin
                apb.psel_o    = 1'b1;
                apb.penable_o = 1'b1;
                apb.pwrite_o  = 1'b1;
                apb.paddr_o   = CTRL_ADDR;
                apb.pwdata_o  = INIT_CTRL;
                if (apb.pready_i) begin
                    w_err_set = apb.pslverr_i;
                    w_next    = IDLE;
                end
            end
`endif
            default: begin
                w_next = IDLE;
            end
        endcase
        // Outputs are forced low while reset is held, even when the
        // reset state itself would drive the bus.
        if (preset_i) begin
            w_accept      = 1'b0;
            w_err_set     = 1'b0;
            req_ready_o   = '0;
            busy_o        = 1'b0;
            apb.psel_o    = 1'b0;
            apb.penable_o = 1'b0;
            apb.pwrite_o  = 1'b0;
            apb.paddr_o   = '0;
            apb.pwdata_o  = '0;
        end
    end

    always_ff @(posedge pclk_i or posedge preset_i) begin
        if (preset_i) begin
            r_ptr   <= '0;
            r_grant <= '0;
            r_byte  <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_byte  <= w_sel_byte;
                r_grant <= w_winner;
                r_ptr   <= (w_winner == IDW'(N_REQ - 1)) ? '0 : w_winner + IDW'(1);
            end
            // A set in the same cycle as a clear wins.
            if (w_err_set) begin
                r_err <= 1'b1;
            end else if (err_clr_i) begin
                r_err <= 1'b0;
            end
        end
    end

    assign grant_id_o = r_grant;
    assign err_o      = r_err;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb/tb_uart_tx_scheduler.sv - directed table-driven bench for uart_tx_scheduler
module tb_uart_tx_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        busy;
    logic [1:0]  grant_id;
    logic        err;
    logic        err_clr = 1'b0;

    always #5 clk = ~clk;

    uart_tx_scheduler_if apb();

    uart_tx_scheduler #(.N_REQ(4)) dut (
        .pclk_i      (clk),
        .preset_i    (rst),
        .req_valid_i (req_valid),
        .req_data_i  (req_data),
        .req_ready_o (req_ready),
        .apb         (apb),
        .busy_o      (busy),
        .grant_id_o  (grant_id),
        .err_o       (err),
        .err_clr_i   (err_clr)
    );

    typedef struct {
        logic [3:0] mask;
        int         full;
        int         ws;
        bit         wrerr;
        int         g;
        bit         exp_err;
    } vec_t;

    vec_t tbl[10];

    int checks = 0;
    int errors = 0;

    int cfg_ws = 0;
    bit cfg_wrerr = 1'b0;
    int full_left = 0;
    int wcnt = 0;
    int n_rd = 0;
    int n_wr = 0;
    int bad_rd = 0;
    logic [7:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [7:0]  first_wr_addr = '0;
    logic [31:0] first_wr_data = '0;

    int rdy_cnt[4] = '{0, 0, 0, 0};
    int exp_cnt[4] = '{0, 0, 0, 0};
    int rdy_busy = 0;
    logic [7:0] dbyte[4] = '{8'hA5, 8'h3C, 8'h5A, 8'hC3};

    assign req_data = {dbyte[3], dbyte[2], dbyte[1], dbyte[0]};

    // UART slave model: wait states, programmable number of "full" replies.
    always @(negedge clk) begin
        apb.pready_i  = 1'b0;
        apb.pslverr_i = 1'b0;
        apb.prdata_i  = '0;
        if (rst) begin
            wcnt = 0;
        end else if (apb.psel_o && apb.penable_o) begin
            if (wcnt < cfg_ws) begin
                wcnt++;
            end else begin
                wcnt = 0;
                apb.pready_i = 1'b1;
                if (apb.pwrite_o) begin
                    if (n_wr == 0) begin
                        first_wr_addr = apb.paddr_o;
                        first_wr_data = apb.pwdata_o;
                    end
                    n_wr++;
                    wr_addr = apb.paddr_o;
                    wr_data = apb.pwdata_o;
                    apb.pslverr_i = cfg_wrerr;
                end else begin
                    n_rd++;
                    if (apb.paddr_o != 8'h08) bad_rd++;
                    if (full_left > 0) begin
                        apb.prdata_i = 32'h8000_0001;
                        full_left--;
                    end else begin
                        apb.prdata_i = 32'hFFFF_FFFE;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        #2;
        for (int i = 0; i < 4; i++) begin
            if (req_ready[i]) rdy_cnt[i]++;
        end
        if (req_ready != 4'b0 && busy) rdy_busy++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic wait_ready(input string tag, output bit got);
        got = 1'b0;
        for (int k = 0; k < 50; k++) begin
            #1;
            if (req_ready != 4'b0) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s_ready_timeout actual=0 required=1", tag);
        end
    endtask

    task automatic run_xfer(input logic [3:0] mask, input int full, input int ws,
                            input bit wrerr, input int g, input bit exp_err, input string tag);
        int n;
        bit got;
        full_left = full;
        cfg_ws    = ws;
        cfg_wrerr = wrerr;
        req_valid = mask;
        wait_ready(tag, got);
        if (!got) return;
        n_rd = 0;
        n_wr = 0;
        bad_rd = 0;
        chk({tag, "_ready"}, 32'(req_ready), 32'(4'b0001 << g));
        exp_cnt[g]++;
        @(negedge clk);
        #1;
        chk({tag, "_poll_setup"}, {21'h0, apb.psel_o, apb.penable_o, apb.pwrite_o, apb.paddr_o},
            {21'h0, 3'b100, 8'h08});
        n = 1;
        while (busy && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk({tag, "_cycles"}, n, 5 + 2 * full + ws * (full + 2));
        chk({tag, "_grant_id"}, 32'(grant_id), g);
        chk({tag, "_reads"}, n_rd, full + 1);
        chk({tag, "_read_addr"}, bad_rd, 0);
        chk({tag, "_writes"}, n_wr, 1);
        chk({tag, "_wr_addr"}, 32'(wr_addr), 32'h0);
        chk({tag, "_wr_data"}, wr_data, {24'h0, dbyte[g]});
        chk({tag, "_err"}, 32'(err), 32'(exp_err));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        bit got;
        tbl[0] = '{4'b0001, 0, 0, 1'b0, 0, 1'b0};
        tbl[1] = '{4'b1111, 0, 0, 1'b0, 1, 1'b0};
        tbl[2] = '{4'b1111, 0, 0, 1'b0, 2, 1'b0};
        tbl[3] = '{4'b1111, 0, 0, 1'b0, 3, 1'b0};
        tbl[4] = '{4'b1111, 0, 0, 1'b0, 0, 1'b0};
        tbl[5] = '{4'b1000, 3, 0, 1'b0, 3, 1'b0};
        tbl[6] = '{4'b0110, 0, 1, 1'b0, 1, 1'b0};
        tbl[7] = '{4'b0101, 1, 2, 1'b0, 2, 1'b0};
        tbl[8] = '{4'b0011, 0, 0, 1'b0, 0, 1'b0};
        tbl[9] = '{4'b0001, 0, 0, 1'b1, 0, 1'b1};

        repeat (3) @(negedge clk);
        #1;
        chk("rst_apb", {29'h0, apb.psel_o, apb.penable_o, apb.pwrite_o}, 32'h0);
        chk("rst_paddr_pwdata", {24'h0, apb.paddr_o} | apb.pwdata_o, 32'h0);
        chk("rst_status", {27'h0, busy, grant_id, err, 1'b0}, 32'h0);
        chk("rst_ready", 32'(req_ready), 32'h0);

`ifdef UART_TX_SCHED_INIT_EN
        req_valid = 4'b1111;
`endif
        @(negedge clk);
        rst = 1'b0;
`ifdef UART_TX_SCHED_INIT_EN
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            #1;
            if (!busy) break;
        end
        chk("init_done", 32'(busy), 32'h0);
        chk("init_writes", n_wr, 1);
        chk("init_reads", n_rd, 0);
        chk("init_addr", 32'(first_wr_addr), 32'h0C);
        chk("init_data", first_wr_data, 32'h1);
`endif

        for (int i = 0; i < 10; i++) begin
            run_xfer(tbl[i].mask, tbl[i].full, tbl[i].ws, tbl[i].wrerr,
                     tbl[i].g, tbl[i].exp_err, $sformatf("vec%0d", i));
        end
        req_valid = 4'b0;

        err_clr = 1'b1;
        @(negedge clk);
        #1;
        err_clr = 1'b0;
        chk("err_clear", 32'(err), 32'h0);

        cfg_wrerr = 1'b1;
        cfg_ws    = 0;
        full_left = 0;
        req_valid = 4'b0100;
        wait_ready("err_seq", got);
        if (got) begin
            chk("err_seq_ready", 32'(req_ready), 32'h4);
            exp_cnt[2]++;
            @(negedge clk);
            #1;
            req_valid = 4'b0;
            n_wr = 0;
            for (int k = 0; k < 40; k++) begin
                @(negedge clk);
                #1;
                if (apb.psel_o && apb.penable_o && apb.pwrite_o) break;
            end
            err_clr = 1'b1;
            @(negedge clk);
            #1;
            err_clr = 1'b0;
            chk("err_set_wins", 32'(err), 32'h1);
            chk("err_idle_next", 32'(busy), 32'h0);
            repeat (8) @(negedge clk);
            #1;
            chk("err_no_retry", n_wr, 1);
            chk("err_still_idle", 32'(busy), 32'h0);
            err_clr = 1'b1;
            @(negedge clk);
            #1;
            err_clr = 1'b0;
            chk("err_later_clear", 32'(err), 32'h0);
        end
        cfg_wrerr = 1'b0;

        cfg_ws    = 30;
        full_left = 0;
        req_valid = 4'b0010;
        wait_ready("rst_seq", got);
        if (got) begin
            chk("rst_seq_ready", 32'(req_ready), 32'h2);
            exp_cnt[1]++;
            @(negedge clk);
            #1;
            req_valid = 4'b0;
            for (int k = 0; k < 40; k++) begin
                @(negedge clk);
                #1;
                if (apb.psel_o && apb.penable_o && apb.pwrite_o) break;
            end
            chk("rst_seq_in_wr_a", {30'h0, apb.penable_o, apb.pwrite_o}, 32'h3);
            #1;
            rst = 1'b1;
            #1;
            chk("rst_async_apb", {30'h0, apb.psel_o, apb.penable_o}, 32'h0);
            chk("rst_async_busy", 32'(busy), 32'h0);
            cfg_ws = 0;
            @(negedge clk);
            @(negedge clk);
            rst = 1'b0;
            run_xfer(4'b1111, 0, 0, 1'b0, 0, 1'b0, "post_rst");
        end
        req_valid = 4'b0;
        repeat (2) @(negedge clk);
        #3;

        for (int i = 0; i < 4; i++) begin
            chk($sformatf("ready_count%0d", i), rdy_cnt[i], exp_cnt[i]);
        end
        chk("ready_while_busy", rdy_busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
